// File: rtl/teclado_cajero.sv
// teclado_cajero: 4x4 matrix-keypad front end for the ATM controller.
// Scans columns one-hot, synchronizes and debounces the row returns, and turns
// each accepted press into a single-cycle PIN-entry event.
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   TARJETA_RECIBIDA card present; keypad enabled only while high
//   FILAS[3:0]       raw row returns, active-high, asynchronous
//   COLUMNAS[3:0]    one-hot column drive
//   DIGITO[3:0]      last accepted digit (0-9), held between strobes
//   DIGITO_STB       one-cycle pulse, DIGITO valid in the same cycle
//   ENTER_PIN        one-cycle pulse for '#'
//   ERASE_PIN        one-cycle pulse for '*'
module teclado_cajero #(
  parameter int unsigned SCAN_HOLD       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TARJETA_RECIBIDA,
  input  logic [3:0] FILAS,
  output logic [3:0] COLUMNAS,
  output logic [3:0] DIGITO,
  output logic       DIGITO_STB,
  output logic       ENTER_PIN,
  output logic       ERASE_PIN
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [3:0]          filas_meta, filas_s;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [3:0]          row_lat, row_n;
  logic [3:0]          cols_n, cols_rot;
  logic [3:0]          digito_n;
  logic                stb_n, enter_n, erase_n;
  logic [1:0]          r_idx, c_idx;
  logic                filas_onehot, last_hold, cnt_last;

  // Binary row/column of the latched key; COLUMNAS is frozen on the key column.
  assign r_idx = {row_lat[3] | row_lat[2], row_lat[3] | row_lat[1]};
  assign c_idx = {COLUMNAS[3] | COLUMNAS[2], COLUMNAS[3] | COLUMNAS[1]};

  assign cols_rot     = {COLUMNAS[2:0], COLUMNAS[3]};
  assign filas_onehot = (filas_s != 4'd0) && ((filas_s & (filas_s - 4'd1)) == 4'd0);
  assign last_hold    = (hold_cnt == HOLD_W'(SCAN_HOLD - 1));
  // Acting one count early means the counter never exceeds DEBOUNCE_CYCLES-1.
  assign cnt_last     = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_SCAN;
      filas_meta <= 4'd0;
      filas_s    <= 4'd0;
      hold_cnt   <= '0;
      cnt        <= '0;
      row_lat    <= 4'd0;
      COLUMNAS   <= 4'b0001;
      DIGITO     <= 4'd0;
      DIGITO_STB <= 1'b0;
      ENTER_PIN  <= 1'b0;
      ERASE_PIN  <= 1'b0;
    end else begin
      state      <= state_n;
      filas_meta <= FILAS;
      filas_s    <= filas_meta;
      hold_cnt   <= hold_n;
      cnt        <= cnt_n;
      row_lat    <= row_n;
      COLUMNAS   <= cols_n;
      DIGITO     <= digito_n;
      DIGITO_STB <= stb_n;
      ENTER_PIN  <= enter_n;
      ERASE_PIN  <= erase_n;
    end
  end

  // Next-state, scan/debounce counters and event decode.
  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    cnt_n    = cnt;
    row_n    = row_lat;
    cols_n   = COLUMNAS;
    digito_n = DIGITO;
    stb_n    = 1'b0;
    enter_n  = 1'b0;
    erase_n  = 1'b0;

    unique case (state)
      S_SCAN: begin
        if (last_hold) begin
          hold_n = '0;
          if (filas_onehot) begin
            row_n   = filas_s;
            cnt_n   = '0;
            state_n = S_DEBOUNCE;
          end else begin
            cols_n = cols_rot;
          end
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end

      S_DEBOUNCE: begin
        if (filas_s == row_lat) begin
          if (cnt_last) begin
            cnt_n   = '0;
            state_n = S_HELD;
            // Column 3 holds the letter keys: accepted but silent.
            if (c_idx != 2'd3) begin
              if (r_idx != 2'd3) begin
                stb_n    = 1'b1;
                digito_n = {2'b00, r_idx} * 4'd3 + {2'b00, c_idx} + 4'd1;
              end else if (c_idx == 2'd0) begin
                erase_n = 1'b1;
              end else if (c_idx == 2'd1) begin
                stb_n    = 1'b1;
                digito_n = 4'd0;
              end else begin
                enter_n = 1'b1;
              end
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else begin
          state_n = S_SCAN;
          cnt_n   = '0;
          cols_n  = cols_rot;
          hold_n  = '0;
        end
      end

      S_HELD: begin
        if ((filas_s & row_lat) == 4'd0) begin
          if (cnt_last) begin
            cnt_n   = '0;
            state_n = S_SCAN;
            cols_n  = cols_rot;
            hold_n  = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end

      default: begin
        state_n = S_SCAN;
        cnt_n   = '0;
        hold_n  = '0;
      end
    endcase

    // No card: stay scanning, drop any event in flight, keep DIGITO.
    if (!TARJETA_RECIBIDA) begin
      state_n  = S_SCAN;
      cnt_n    = '0;
      stb_n    = 1'b0;
      enter_n  = 1'b0;
      erase_n  = 1'b0;
      digito_n = DIGITO;
    end
  end

endmodule
